// File: rtl/dbus_arbiter_pkg.sv
// Shared types for the data-bus arbiter: FSM states, owner encoding, latched transaction.
// Pure declarations; no latency and no backpressure of its own.
package dbus_arbiter_pkg;

  typedef enum logic [1:0] {
    DBUS_IDLE = 2'd0,
    DBUS_CPU  = 2'd1,
    DBUS_DMA  = 2'd2
  } dbus_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } dbus_owner_t;

  localparam int DBUS_TIMEOUT_DEF = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } dbus_txn_t;

endpackage

// File: rtl/dbus_arbiter_if.sv
// CPU, DMA and memory-port signals of the data-bus arbiter.
// slave = arbiter side; master = pipeline/DMA/memory side.
interface dbus_arbiter_if;

  logic        cpu_req;
  logic        cpu_kill;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_buserr;

  logic        dma_req;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_byteen;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic        dma_err;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_kill, cpu_addr, cpu_wdata, cpu_byteen,
    output cpu_rdata, cpu_stall, cpu_buserr,
    input  dma_req, dma_addr, dma_wdata, dma_byteen,
    output dma_ack, dma_rdata, dma_err,
    output mem_req, mem_addr, mem_wdata, mem_byteen,
    input  mem_ack, mem_rdata
  );

  modport master (
    output cpu_req, cpu_kill, cpu_addr, cpu_wdata, cpu_byteen,
    input  cpu_rdata, cpu_stall, cpu_buserr,
    output dma_req, dma_addr, dma_wdata, dma_byteen,
    input  dma_ack, dma_rdata, dma_err,
    input  mem_req, mem_addr, mem_wdata, mem_byteen,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/dbus_arbiter_rr_arb2.sv
// Two-input round-robin picker; grants are combinational, last_owner updates on a grant.
// Zero latency; a loser simply keeps requesting and wins the next tie.
module dbus_arbiter_rr_arb2
  import dbus_arbiter_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_req_cpu,
  input  logic i_req_dma,
  output logic o_gnt_cpu,
  output logic o_gnt_dma
);

  dbus_owner_t r_last_owner;
  logic        w_pick_cpu;

  // On a tie the master that did not win last time goes first.
  assign w_pick_cpu = i_req_cpu & (~i_req_dma | (r_last_owner == OWN_DMA));
  assign o_gnt_cpu  = i_en & w_pick_cpu;
  assign o_gnt_dma  = i_en & i_req_dma & ~w_pick_cpu;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_owner <= OWN_DMA;
    end else if (o_gnt_cpu) begin
      r_last_owner <= OWN_CPU;
    end else if (o_gnt_dma) begin
      r_last_owner <= OWN_DMA;
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Shares one data-memory port between the M-stage and DMA; holds each transaction until ack or timeout.
// Grant at the IDLE edge, mem_req next cycle; CPU is back-pressured via cpu_stall, DMA holds dma_req.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DBUS_TIMEOUT_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  dbus_arbiter_if.slave bus
);

  localparam int             CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  dbus_state_t   r_state;
  dbus_state_t   w_state_nxt;
  dbus_txn_t     r_txn;
  logic [CW-1:0] r_cnt;

  logic w_cpu_eff;
  logic w_idle;
  logic w_busy;
  logic w_gnt_cpu;
  logic w_gnt_dma;
  logic w_timeout;
  logic w_ack_ok;

  assign w_cpu_eff = bus.cpu_req & ~bus.cpu_kill;
  assign w_idle    = (r_state == DBUS_IDLE);
  assign w_busy    = ~w_idle;
  // An ack in the last allowed cycle wins over the timeout.
  assign w_timeout = w_busy & ~bus.mem_ack & (r_cnt == CNT_LAST);
  // Completion pulses are suppressed while reset aborts a transaction.
  assign w_ack_ok  = bus.mem_ack & ~i_reset;

  dbus_arbiter_rr_arb2 u_rr (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_en      (w_idle),
    .i_req_cpu (w_cpu_eff),
    .i_req_dma (bus.dma_req),
    .o_gnt_cpu (w_gnt_cpu),
    .o_gnt_dma (w_gnt_dma)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= DBUS_IDLE;
      r_txn   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt_cpu) begin
        r_txn.addr   <= bus.cpu_addr;
        r_txn.wdata  <= bus.cpu_wdata;
        r_txn.byteen <= bus.cpu_byteen;
        r_cnt        <= '0;
      end else if (w_gnt_dma) begin
        r_txn.addr   <= bus.dma_addr;
        r_txn.wdata  <= bus.dma_wdata;
        r_txn.byteen <= bus.dma_byteen;
        r_cnt        <= '0;
      end else if (w_busy && !bus.mem_ack && !w_timeout) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.cpu_stall  = w_cpu_eff;
    bus.cpu_rdata  = '0;
    bus.cpu_buserr = 1'b0;
    bus.dma_ack    = 1'b0;
    bus.dma_rdata  = '0;
    bus.dma_err    = 1'b0;
    case (r_state)
      DBUS_IDLE: begin
        if (w_gnt_cpu) begin
          w_state_nxt = DBUS_CPU;
        end else if (w_gnt_dma) begin
          w_state_nxt = DBUS_DMA;
        end
      end
      DBUS_CPU: begin
        if (bus.mem_ack || w_timeout) begin
          w_state_nxt   = DBUS_IDLE;
          bus.cpu_stall = 1'b0;
        end
        bus.cpu_rdata  = w_ack_ok ? bus.mem_rdata : 32'h0;
        bus.cpu_buserr = w_timeout & ~i_reset;
      end
      DBUS_DMA: begin
        if (bus.mem_ack || w_timeout) begin
          w_state_nxt = DBUS_IDLE;
        end
        bus.dma_ack   = w_ack_ok;
        bus.dma_rdata = w_ack_ok ? bus.mem_rdata : 32'h0;
        bus.dma_err   = w_timeout & ~i_reset;
      end
      default: w_state_nxt = DBUS_IDLE;
    endcase
  end

  // mem_req comes only from the state register, so mem_ack cannot reach it combinationally.
  assign bus.mem_req    = w_busy;
  assign bus.mem_addr   = r_txn.addr;
  assign bus.mem_wdata  = r_txn.wdata;
  assign bus.mem_byteen = r_txn.byteen;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboarded bench for dbus_arbiter: directed CPU/DMA traffic against a delay-programmable memory.
// Expected completions are queued at issue and popped by a monitor whenever the port completes.
module tb_dbus_arbiter;
  import dbus_arbiter_pkg::*;

  localparam int K_CPU_OK  = 0;
  localparam int K_CPU_ERR = 1;
  localparam int K_DMA_OK  = 2;
  localparam int K_DMA_ERR = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic reset;
  dbus_arbiter_if bus ();

  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  int          mem_delay = 1;
  logic [31:0] mem_xor = 32'h0;
  logic        late_ack = 1'b0;

  exp_t        mon_e;
  int          mon_kind;
  logic [31:0] mon_rd;

  dbus_arbiter #(.TIMEOUT(16)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] rd);
    exp_t e;
    e.kind = k; e.addr = a; e.wdata = wd; e.be = be; e.rdata = rd;
    sb.push_back(e);
  endtask

  // Memory model: acks in the mem_delay-th cycle of mem_req (0 = never), data = addr ^ mem_xor.
  initial begin : responder
    int n;
    n = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) begin
        n++;
        bus.mem_ack   = (mem_delay != 0) && (n == mem_delay);
        bus.mem_rdata = bus.mem_ack ? (bus.mem_addr ^ mem_xor) : 32'h0;
      end else begin
        n = 0;
        bus.mem_ack   = late_ack;
        bus.mem_rdata = late_ack ? 32'hBAD0BAD0 : 32'h0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus.mem_req && (bus.mem_ack || bus.cpu_buserr || bus.dma_err)) begin
      mon_kind = bus.dma_ack ? K_DMA_OK : bus.dma_err ? K_DMA_ERR :
                 bus.cpu_buserr ? K_CPU_ERR : K_CPU_OK;
      mon_rd   = (mon_kind >= K_DMA_OK) ? bus.dma_rdata : bus.cpu_rdata;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_completion: kind %0d addr %h with nothing expected", mon_kind, bus.mem_addr);
      end else begin
        mon_e = sb.pop_front();
        chk("mon_kind",   32'(mon_kind),    32'(mon_e.kind));
        chk("mon_addr",   bus.mem_addr,     mon_e.addr);
        chk("mon_wdata",  bus.mem_wdata,    mon_e.wdata);
        chk("mon_byteen", 32'(bus.mem_byteen), 32'(mon_e.be));
        chk("mon_rdata",  mon_rd,           mon_e.rdata);
      end
    end
  end

  task automatic cpu_op(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input int dly, input int exp_stall, input logic [31:0] rd);
    int st;
    bit done;
    push((dly == 0) ? K_CPU_ERR : K_CPU_OK, a, wd, be, (dly == 0) ? 32'h0 : rd);
    mem_delay = dly;
    mem_xor   = rd ^ a;
    step();
    bus.cpu_req = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = wd; bus.cpu_byteen = be;
    st = 0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        chk("mem_addr_hold",   bus.mem_addr,  a);
        chk("mem_wdata_hold",  bus.mem_wdata, wd);
        chk("mem_byteen_hold", 32'(bus.mem_byteen), 32'(be));
      end
      if (bus.cpu_stall) st++;
      else done = 1'b1;
    end
    chk("cpu_done_seen", 32'(done), 32'd1);
    chk("stall_cycles", 32'(st), 32'(exp_stall));
    chk("cpu_buserr", 32'(bus.cpu_buserr), 32'(dly == 0));
    chk("cpu_rdata_done", bus.cpu_rdata, (dly == 0) ? 32'h0 : rd);
    step();
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_byteen = '0;
  endtask

  initial begin
    reset = 1'b1;
    bus.cpu_req = 0; bus.cpu_kill = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_byteen = 0;
    bus.dma_req = 0; bus.dma_addr = 0; bus.dma_wdata = 0; bus.dma_byteen = 0;
    step();
    step();
    @(negedge clk);
    chk("rst_mem_req",    32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr",   bus.mem_addr, 32'h0);
    chk("rst_dma_ack",    32'(bus.dma_ack | bus.dma_err | bus.cpu_buserr), 32'd0);
    chk("rst_stall",      32'(bus.cpu_stall), 32'd0);
    chk("rst_last_owner", 32'(dut.u_rr.r_last_owner), 32'(OWN_DMA));
    step();
    reset = 1'b0;

    // Simultaneous requests: CPU first, then DMA beats a fresh CPU request, then CPU.
    mem_delay = 1;
    mem_xor   = 32'h0F0F_0000;
    push(K_CPU_OK, 32'h2000, 32'h0, 4'h0, 32'h2000 ^ 32'h0F0F_0000);
    push(K_DMA_OK, 32'h3000, 32'hCAFE_0001, 4'hF, 32'h3000 ^ 32'h0F0F_0000);
    push(K_CPU_OK, 32'h2008, 32'h55, 4'h1, 32'h2008 ^ 32'h0F0F_0000);
    step();
    bus.cpu_req = 1; bus.cpu_addr = 32'h2000;
    bus.dma_req = 1; bus.dma_addr = 32'h3000; bus.dma_wdata = 32'hCAFE_0001; bus.dma_byteen = 4'hF;
    @(negedge clk);
    chk("tie_idle_stall", 32'(bus.cpu_stall), 32'd1);
    chk("tie_idle_mreq",  32'(bus.mem_req), 32'd0);
    step();
    @(negedge clk);
    chk("tie_first_addr", bus.mem_addr, 32'h2000);
    chk("tie_first_stall", 32'(bus.cpu_stall), 32'd0);
    step();
    bus.cpu_addr = 32'h2008; bus.cpu_wdata = 32'h55; bus.cpu_byteen = 4'h1;
    @(negedge clk);
    chk("gap_mreq", 32'(bus.mem_req), 32'd0);
    chk("gap_stall", 32'(bus.cpu_stall), 32'd1);
    chk("owner_after_cpu", 32'(dut.u_rr.r_last_owner), 32'(OWN_CPU));
    step();
    @(negedge clk);
    chk("dma_second_addr", bus.mem_addr, 32'h3000);
    chk("dma_ack_pulse", 32'(bus.dma_ack), 32'd1);
    chk("cpu_waits_stall", 32'(bus.cpu_stall), 32'd1);
    step();
    bus.dma_req = 0;
    @(negedge clk);
    chk("owner_after_dma", 32'(dut.u_rr.r_last_owner), 32'(OWN_DMA));
    chk("dma_ack_one_cycle", 32'(bus.dma_ack), 32'd0);
    step();
    @(negedge clk);
    chk("third_addr", bus.mem_addr, 32'h2008);
    chk("third_stall", 32'(bus.cpu_stall), 32'd0);
    step();
    bus.cpu_req = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_byteen = 0;

    cpu_op(32'h0000_1004, 32'h0, 4'b0000, 1, 1, 32'hDEAD_BEEF);
    cpu_op(32'h0000_4000, 32'h00AB_0000, 4'b0100, 5, 5, 32'h1234_5678);

    // Kill before grant blocks the access; kill after grant does not.
    mem_delay = 3;
    mem_xor   = 32'h6000 ^ 32'hA1B2_C3D4;
    step();
    bus.cpu_req = 1; bus.cpu_kill = 1; bus.cpu_addr = 32'h6000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("kill_no_mreq", 32'(bus.mem_req), 32'd0);
      chk("kill_no_stall", 32'(bus.cpu_stall), 32'd0);
      step();
    end
    push(K_CPU_OK, 32'h6000, 32'h0, 4'h0, 32'hA1B2_C3D4);
    bus.cpu_kill = 0;
    @(negedge clk);
    chk("kill_off_stall", 32'(bus.cpu_stall), 32'd1);
    step();
    bus.cpu_kill = 1;
    @(negedge clk);
    chk("late_kill_mreq", 32'(bus.mem_req), 32'd1);
    step();
    @(negedge clk);
    chk("late_kill_hold", bus.mem_addr, 32'h6000);
    step();
    @(negedge clk);
    chk("late_kill_ack_cycle", 32'(bus.mem_req & bus.mem_ack), 32'd1);
    step();
    bus.cpu_req = 0; bus.cpu_kill = 0; bus.cpu_addr = 0;
    @(negedge clk);
    chk("late_kill_released", 32'(bus.mem_req), 32'd0);

    cpu_op(32'h0000_5000, 32'h0, 4'b0000, 0, 16, 32'h0);
    @(negedge clk);
    late_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      chk("idle_ack_mreq", 32'(bus.mem_req), 32'd0);
      chk("idle_ack_outs", 32'(bus.dma_ack | bus.cpu_buserr | bus.dma_err), 32'd0);
      chk("idle_ack_rdata", bus.cpu_rdata | bus.dma_rdata, 32'h0);
    end
    late_ack = 1'b0;

    // Reset during a DMA transaction the memory never answers.
    mem_delay = 0;
    step();
    bus.dma_req = 1; bus.dma_addr = 32'h7000; bus.dma_wdata = 32'h99; bus.dma_byteen = 4'h2;
    step();
    step();
    step();
    @(negedge clk);
    chk("dma_busy_mreq", 32'(bus.mem_req), 32'd1);
    chk("dma_busy_addr", bus.mem_addr, 32'h7000);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_no_pulse", 32'(bus.dma_ack | bus.dma_err), 32'd0);
    step();
    reset = 1'b0; bus.dma_req = 0;
    @(negedge clk);
    chk("rst_mid_mreq", 32'(bus.mem_req), 32'd0);
    chk("rst_mid_addr", bus.mem_addr, 32'h0);
    for (int i = 0; i < 20; i++) begin
      step();
      @(negedge clk);
      chk("rst_mid_quiet", 32'(bus.mem_req | bus.dma_ack | bus.dma_err), 32'd0);
    end

    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-master arbiter for the single external data-memory port. Shares the port between the M-stage load/store path and a DMA master. Latches each granted transaction and holds it stable until the memory acknowledges. Drives the M-stage stall to the hazard unit while a CPU access is outstanding, and reports a bus error if the memory fails to acknowledge within a timeout.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles an issued transaction may wait for mem_ack; must be ≥2.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  M-stage instruction is a load or store
- cpu_kill  in  1  exception request (Req) this cycle; suppresses a not-yet-granted CPU access
- cpu_addr  in  32  byte address from the ALU result
- cpu_wdata  in  32  lane-aligned store data
- cpu_byteen  in  4  store byte enables; 0 means read
- cpu_rdata  out  32  raw memory word; valid in the cpu_done cycle
- cpu_stall  out  1  freeze the pipeline up to and including M
- cpu_buserr  out  1  one-cycle pulse: CPU transaction timed out
- dma_req  in  1  DMA access request; held until dma_ack or dma_err
- dma_addr  in  32  DMA byte address
- dma_wdata  in  32  DMA store data
- dma_byteen  in  4  0 means read
- dma_ack  out  1  one-cycle completion pulse
- dma_rdata  out  32  valid with dma_ack
- dma_err  out  1  one-cycle pulse: DMA transaction timed out
- mem_req  out  1  transaction outstanding on memory port
- mem_addr  out  32  latched address
- mem_wdata  out  32  latched data
- mem_byteen  out  4  latched enables
- mem_ack  in  1  memory completion; accepted only while mem_req=1
- mem_rdata  in  32  read data, valid with mem_ack

## Operation
- FSM states: IDLE, CPU_BUSY, DMA_BUSY. Reset → IDLE.
- Effective CPU request: cpu_req & ~cpu_kill.
- Arbitration in IDLE:
  - Only one master requesting: that master wins.
  - Both requesting: winner is the master not recorded in last_owner.
  - last_owner resets to DMA, so the CPU wins the first tie.
- On grant:
  - Latch the winner's addr, wdata and byteen into mem_* registers.
  - Update last_owner and clear the wait counter.
  - Move to the owner's BUSY state.
- In BUSY, mem_req=1 and mem_* are held stable.
- Normal completion: mem_ack → return to IDLE. Either:
  - CPU_BUSY: cpu_rdata=mem_rdata combinationally that cycle and cpu_stall=0; or
  - DMA_BUSY: dma_ack=1 and dma_rdata=mem_rdata.
- Timeout:
  - The wait counter increments each BUSY cycle without mem_ack.
  - The cycle it equals TIMEOUT-1 with no ack: pulse cpu_buserr or dma_err, read data=0, return to IDLE, mem_req drops the next cycle.
  - mem_ack in the same cycle as the timeout counts as success.
- Stall equation: cpu_stall = (cpu_req & ~cpu_kill) & ~(state==CPU_BUSY & (mem_ack | timeout)).
- cpu_kill is honoured only before grant. Once CPU_BUSY is entered, the transaction always runs to ack or timeout. The pipeline must not take the exception while cpu_stall=1.
- No combinational path exists from mem_ack to mem_req.
- mem_ack seen in IDLE is ignored.

## Timing
- Reset values:
  - State registers: state=IDLE, last_owner=DMA, counter=0.
  - Outputs: mem_req=0, mem_addr/wdata/byteen=0, dma_ack=0, dma_err=0, cpu_buserr=0.
  - cpu_rdata and dma_rdata read 0 when not in their done cycle.
  - cpu_stall remains combinational in the reset cycle.
- Minimum CPU latency:
  - Request seen in IDLE in cycle 0: stall=1, grant at the edge.
  - Cycle 1: mem_req=1. If mem_ack=1, done and stall=0.
  - Total: one stall cycle.
- Back-to-back: after completion the next grant occurs in the following IDLE cycle, so there is always one IDLE cycle between transactions.
- Timeout completes TIMEOUT cycles after grant, counting BUSY cycles only.
- Reset mid-transaction: FSM returns to IDLE at once with no ack or err pulse. The memory must also be reset.

## Structure
- HEAD.v: state encodings `DBUS_IDLE/`DBUS_CPU/`DBUS_DMA, owner encodings, default TIMEOUT.
- Sub-module rr_arb2: two-input round-robin with last_owner register.
- Top level holds the FSM, latch registers and timeout counter.

## Test plan
- CPU lw at 0x0000_1004, mem_ack in cycle 1 with mem_rdata=0xDEADBEEF → cpu_stall high for exactly 1 cycle; cpu_rdata=0xDEADBEEF in the done cycle; mem_byteen=0.
- CPU and DMA request in the same cycle after reset → CPU granted first. While the DMA waits, a second CPU request → DMA granted next. Check last_owner alternates.
- CPU sb with byteen=0100 and wdata=0x00AB0000, memory delays ack 5 cycles → mem_* stable for all 5 cycles; stall lasts 5 cycles.
- cpu_req with cpu_kill=1 in IDLE → no grant, mem_req=0, cpu_stall=0. Same kill raised after grant → transaction still completes.
- Memory never acks, TIMEOUT=16 → cpu_buserr pulses 16 cycles after grant, cpu_rdata=0, return to IDLE. A late mem_ack in IDLE is ignored.
- Reset asserted while in DMA_BUSY → next cycle mem_req=0, state IDLE, no dma_ack or dma_err.
